// File: rtl/video_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : video_pattern_gen
// Description : Raster test-pattern source (solid, ramp, pulse, checker) on an
//               AXI-Stream style pixel interface.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module video_pattern_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CH_COUNT    = 1,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                            p_in_clk,
  input  logic                            p_in_rst,
  input  logic                            p_in_start,
  input  logic                            p_in_cont,
  input  logic [1:0]                      p_in_mode,
  input  logic [DIM_WIDTH-1:0]            p_in_w,
  input  logic [DIM_WIDTH-1:0]            p_in_h,
  input  logic [DIM_WIDTH-1:0]            p_in_cx,
  input  logic [DIM_WIDTH-1:0]            p_in_cy,
  input  logic [PIXEL_WIDTH-1:0]          p_in_val,
  input  logic [3:0]                      p_in_blk,
  output logic [PIXEL_WIDTH*CH_COUNT-1:0] p_out_tdata,
  output logic                            p_out_tvalid,
  input  logic                            p_in_tready,
  output logic                            p_out_tuser,
  output logic                            p_out_tlast,
  output logic                            p_out_busy,
  output logic                            p_out_frame_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [PIXEL_WIDTH-1:0] C_FS     = {PIXEL_WIDTH{1'b1}};
  localparam logic [PIXEL_WIDTH+1:0] C_FS3    = {1'b0, C_FS, 1'b0} + {2'b00, C_FS};
  localparam logic [PIXEL_WIDTH+1:0] C_L1_EXT = C_FS3 >> 2;
  localparam logic [PIXEL_WIDTH+1:0] C_L2_EXT = C_FS3 >> 3;
  localparam logic [PIXEL_WIDTH-1:0] C_LVL1   = C_L1_EXT[PIXEL_WIDTH-1:0];
  localparam logic [PIXEL_WIDTH-1:0] C_LVL2   = C_L2_EXT[PIXEL_WIDTH-1:0];
  localparam logic [PIXEL_WIDTH-1:0] C_LVL3   = C_FS >> 3;

  state_t                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic                   frame_done_q, frame_done_d;
  logic                   load_cfg;
  logic [1:0]             mode_q;
  logic [DIM_WIDTH-1:0]   w_q, h_q, cx_q, cy_q;
  logic [PIXEL_WIDTH-1:0] val_q;
  logic [3:0]             blk_q;

  logic                   cfg_ok, last_x, last_y;
  logic [DIM_WIDTH-1:0]   dx;
  logic [DIM_WIDTH-1:0]   cell_x, cell_y;
  logic [PIXEL_WIDTH-1:0] ramp_val, pix;

  assign cfg_ok = (p_in_w != '0) && (p_in_h != '0);
  assign last_x = (x_q == w_q - DIM_WIDTH'(1));
  assign last_y = (y_q == h_q - DIM_WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    load_cfg     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p_in_start && cfg_ok) begin
          load_cfg = 1'b1;
          state_d  = S_RUN;
          x_d      = '0;
          y_d      = '0;
        end
      end
      S_RUN: begin
        if (p_in_tready) begin
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              // Continuous mode re-latches config so the next frame starts seamlessly
              if (p_in_cont && cfg_ok) load_cfg = 1'b1;
              else                     state_d  = S_IDLE;
            end else begin
              y_d = y_q + DIM_WIDTH'(1);
            end
          end else begin
            x_d = x_q + DIM_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      mode_q       <= '0;
      w_q          <= '0;
      h_q          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      val_q        <= '0;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      if (load_cfg) begin
        mode_q <= p_in_mode;
        w_q    <= p_in_w;
        h_q    <= p_in_h;
        cx_q   <= p_in_cx;
        cy_q   <= p_in_cy;
        val_q  <= p_in_val;
        blk_q  <= p_in_blk;
      end
    end
  end

  generate
    if (PIXEL_WIDTH <= DIM_WIDTH) begin : g_ramp_narrow
      assign ramp_val = x_q[PIXEL_WIDTH-1:0];
    end else begin : g_ramp_wide
      assign ramp_val = {{(PIXEL_WIDTH-DIM_WIDTH){1'b0}}, x_q};
    end
  endgenerate

  assign dx     = (x_q >= cx_q) ? (x_q - cx_q) : (cx_q - x_q);
  assign cell_x = x_q >> blk_q;
  assign cell_y = y_q >> blk_q;

  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0: pix = val_q;
      2'd1: pix = ramp_val;
      2'd2: begin
        // An off-frame centre blanks the whole frame, not just the clipped tail
        if ((cx_q < w_q) && (cy_q < h_q) && (y_q == cy_q)) begin
          if      (dx == DIM_WIDTH'(0)) pix = C_FS;
          else if (dx == DIM_WIDTH'(1)) pix = C_LVL1;
          else if (dx == DIM_WIDTH'(2)) pix = C_LVL2;
          else if (dx == DIM_WIDTH'(3)) pix = C_LVL3;
        end
      end
      default: pix = (cell_x[0] ^ cell_y[0]) ? C_FS : '0;
    endcase
  end

  assign p_out_tvalid     = (state_q == S_RUN);
  assign p_out_busy       = (state_q == S_RUN);
  assign p_out_tuser      = p_out_tvalid && (x_q == '0) && (y_q == '0);
  assign p_out_tlast      = p_out_tvalid && last_x;
  assign p_out_tdata      = p_out_tvalid ? {CH_COUNT{pix}} : '0;
  assign p_out_frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_video_pattern_gen
// Description : Directed vector bench for video_pattern_gen (8-bit, 3 channels).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_pattern_gen;

  localparam int PW = 8;
  localparam int CH = 3;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst, start, cont, tready;
  logic [1:0]      mode;
  logic [DW-1:0]   w, h, cx, cy;
  logic [PW-1:0]   val;
  logic [3:0]      blk;
  logic [PW*CH-1:0] tdata;
  logic            tvalid, tuser, tlast, busy, fdone;

  int checks = 0;
  int errors = 0;

  video_pattern_gen #(.PIXEL_WIDTH(PW), .CH_COUNT(CH), .DIM_WIDTH(DW)) dut (
    .p_in_clk(clk), .p_in_rst(rst), .p_in_start(start), .p_in_cont(cont),
    .p_in_mode(mode), .p_in_w(w), .p_in_h(h), .p_in_cx(cx), .p_in_cy(cy),
    .p_in_val(val), .p_in_blk(blk), .p_out_tdata(tdata), .p_out_tvalid(tvalid),
    .p_in_tready(tready), .p_out_tuser(tuser), .p_out_tlast(tlast),
    .p_out_busy(busy), .p_out_frame_done(fdone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    mode;
    logic [DW-1:0] w, h, cx, cy;
    logic [PW-1:0] val;
    logic [3:0]    blk;
  } cfg_t;

  localparam int NVEC = 7;
  cfg_t vec [NVEC];
  int   vbase [NVEC];

  // Expected channel value per beat, vectors concatenated in table order
  logic [7:0] expv [0:66] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03,
    8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF,
    8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00,
    8'h5A, 8'h5A, 8'h5A, 8'h5A,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'hBF, 8'hFF, 8'hBF, 8'h5F, 8'h1F, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'hFF, 8'h00, 8'hFF,
    8'hFF, 8'hBF, 8'h5F
  };

  logic [7:0] ptab [0:6] = '{8'd31, 8'd95, 8'd191, 8'd255, 8'd191, 8'd95, 8'd31};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    mode = c.mode; w = c.w; h = c.h; cx = c.cx; cy = c.cy; val = c.val; blk = c.blk;
  endtask

  task automatic run_vec(input cfg_t c, input int base, input bit rnd);
    int n, beat, cyc;
    logic [PW*CH-1:0] pd;
    logic pu, pl, stall;
    n = int'(c.w) * int'(c.h);
    apply_cfg(c);
    cont = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scrambled config while running must not affect the frame
    mode = ~c.mode; w = 12'd1; h = 12'd1; cx = 12'd0; cy = 12'd0; val = 8'hEE; blk = 4'd0;
    beat = 0; cyc = 0; stall = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
    while (beat < n && cyc < 400) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start  = (beat < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stall) check("stall_hold", {tuser, tlast, tdata}, {pu, pl, pd});
      if (!tvalid) check("tvalid_gap", tvalid, 1'b1);
      if (fdone) check("early_frame_done", fdone, 1'b0);
      if (tready && tvalid) begin
        check("beat_data", tdata, {CH{expv[base + beat]}});
        check("beat_tuser", tuser, beat == 0);
        check("beat_tlast", tlast, (beat % int'(c.w)) == int'(c.w) - 1);
        beat++;
      end
      stall = tvalid && !tready;
      pd = tdata; pu = tuser; pl = tlast;
      cyc++;
      @(posedge clk); #1;
    end
    if (beat < n) check("frame_timeout", beat, n);
    tready = 1'b1;
    start  = 1'b0;
    check("done_pulse", {fdone, tvalid, busy}, 3'b100);
    @(posedge clk); #1;
    check("done_clear", {fdone, tvalid, busy}, 3'b000);
  endtask

  initial begin
    int fd_cnt, b, px, py;
    logic [7:0] e;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt, px, py, base;
    logic [7:0] e;
    vec[0] = '{2'd1, 12'd4, 12'd2, 12'd0, 12'd0, 8'h00, 4'd0};
    vec[1] = '{2'd3, 12'd4, 12'd4, 12'd0, 12'd0, 8'h00, 4'd1};
    vec[2] = '{2'd0, 12'd2, 12'd2, 12'd0, 12'd0, 8'h5A, 4'd0};
    vec[3] = '{2'd2, 12'd8, 12'd2, 12'd1, 12'd1, 8'h00, 4'd0};
    vec[4] = '{2'd2, 12'd8, 12'd2, 12'd8, 12'd0, 8'h00, 4'd0};
    vec[5] = '{2'd3, 12'd4, 12'd1, 12'd0, 12'd0, 8'h00, 4'd0};
    vec[6] = '{2'd2, 12'd3, 12'd1, 12'd0, 12'd0, 8'h00, 4'd0};
    base = 0;
    for (int i = 0; i < NVEC; i++) begin
      vbase[i] = base;
      base += int'(vec[i].w) * int'(vec[i].h);
    end

    rst = 1'b1; start = 1'b0; cont = 1'b0; tready = 1'b1;
    apply_cfg(vec[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tvalid, tuser, tlast, busy, fdone}, 5'b0);
    check("reset_tdata", tdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vec[i], vbase[i], (i % 2) == 0);

    // 25x25 pulse frame, centre (12,12)
    apply_cfg('{2'd2, 12'd25, 12'd25, 12'd12, 12'd12, 8'h00, 4'd0});
    start = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fd_cnt = 0;
    for (int bt = 0; bt < 625; bt++) begin
      py = bt / 25; px = bt % 25;
      e = (py == 12 && px >= 9 && px <= 15) ? ptab[px - 9] : 8'h00;
      check("pulse_px", {tvalid, tdata}, {1'b1, {CH{e}}});
      if (fdone) fd_cnt++;
      @(posedge clk); #1;
    end
    if (fdone) fd_cnt++;
    check("pulse_end_idle", tvalid, 1'b0);
    @(posedge clk); #1;
    if (fdone) fd_cnt++;
    check("pulse_done_count", fd_cnt, 1);

    // Continuous mode: three back-to-back 2x2 frames
    apply_cfg(vec[2]);
    cont = 1'b1; start = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int bt = 0; bt < 12; bt++) begin
      if (bt == 9) cont = 1'b0;
      check("cont_data", {tvalid, tdata}, {1'b1, 24'h5A5A5A});
      check("cont_tuser", tuser, (bt % 4) == 0);
      check("cont_done", fdone, (bt % 4) == 0 && bt > 0);
      @(posedge clk); #1;
    end
    check("cont_final", {fdone, tvalid, busy}, 3'b100);
    @(posedge clk); #1;

    // Reset mid-frame at pixel (3,5), with a competing start
    apply_cfg('{2'd0, 12'd25, 12'd25, 12'd0, 12'd0, 8'h11, 4'd0});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (128) @(posedge clk);
    #1;
    check("pre_reset_px", {tvalid, tuser, tlast, tdata}, {3'b100, 24'h111111});
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("midreset_flags", {tvalid, busy, tuser, tlast, fdone}, 5'b0);
    check("midreset_tdata", tdata, 0);
    @(posedge clk); #1;
    check("midreset_idle", {tvalid, busy}, 2'b00);
    run_vec(vec[0], vbase[0], 1'b0);

    // Zero-size start requests are ignored
    apply_cfg('{2'd0, 12'd0, 12'd4, 12'd0, 12'd0, 8'h33, 4'd0});
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin w = 12'd4; h = 12'd0; end
      start = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        check("zero_size_idle", {busy, tvalid, fdone}, 3'b000);
      end
      start = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8, bits per channel sample.
REQ-002 Parameter CH_COUNT, default 1, channels per pixel (1..4).
REQ-003 Parameter DIM_WIDTH, default 12, width of all size/coordinate ports.
REQ-004 p_in_clk  input  1  single clock; all logic rising-edge.
REQ-005 p_in_rst  input  1  reset, synchronous, active-high.
REQ-006 p_in_start  input  1  start request, sampled in IDLE only.
REQ-007 p_in_cont  input  1  continuous mode: repeat frames while high.
REQ-008 p_in_mode  input  2  0 solid, 1 h-ramp, 2 delta pulse, 3 checker.
REQ-009 p_in_w, p_in_h  input  DIM_WIDTH each  frame width/height in pixels.
REQ-010 p_in_cx, p_in_cy  input  DIM_WIDTH each  pulse centre.
REQ-011 p_in_val  input  PIXEL_WIDTH  solid-mode level.
REQ-012 p_in_blk  input  4  checker block size = 2^p_in_blk.
REQ-013 p_out_tdata  output  PIXEL_WIDTH*CH_COUNT  pixel, channel c at bits [c*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-014 p_out_tvalid/p_out_tready  output/input  1  AXI-Stream style handshake.
REQ-015 p_out_tuser  output  1  start of frame, first pixel only.
REQ-016 p_out_tlast  output  1  end of line, x = w-1.
REQ-017 p_out_busy  output  1  high in RUN.
REQ-018 p_out_frame_done  output  1  one-cycle pulse after last pixel of each frame is accepted.

Function
REQ-019 FSM states: IDLE, RUN; no others.
REQ-020 IDLE->RUN when p_in_start=1 and w!=0 and h!=0; start with w=0 or h=0 ignored, stays IDLE.
REQ-021 On IDLE->RUN, latch mode, w, h, cx, cy, val, blk; later config changes have no effect until next frame start.
REQ-022 First tvalid=1 the cycle after start accepted (1-cycle latency); x=y=0, tuser=1.
REQ-023 Transfer occurs when tvalid&&tready; tdata/tuser/tlast/tvalid held stable while tvalid&&!tready.
REQ-024 tvalid stays high for all w*h pixels; no gaps generated internally.
REQ-025 Raster order: x increments per transfer; at x=w-1 (tlast=1) x wraps to 0, y increments.
REQ-026 On transfer of (w-1,h-1): frame_done pulses next cycle; if p_in_cont=1, re-latch config and next pixel (0,0,tuser=1) presented with no idle cycle; else ->IDLE, tvalid=0.
REQ-027 p_in_start while in RUN ignored.
REQ-028 FS = 2^PIXEL_WIDTH-1; all channels carry identical value.
REQ-029 Mode 0: value = val.
REQ-030 Mode 1: value = x[PIXEL_WIDTH-1:0] (wraps every 2^PIXEL_WIDTH pixels).
REQ-031 Mode 2: on row y=cy, d=|x-cx| (unsigned, no wrap): d=0 FS; d=1 (3*FS)>>2; d=2 (3*FS)>>3; d=3 FS>>3; else 0; rows y!=cy all 0. 8-bit: 255,191,95,31.
REQ-032 Mode 2 with cx>=w or cy>=h: frame entirely 0; pulse pixels beyond frame edge are simply not emitted.
REQ-033 Mode 3: value = FS if ((x>>blk)^(y>>blk)) bit0 = 1, else 0.
REQ-034 Internal x/y counters DIM_WIDTH bits; w,h up to 2^DIM_WIDTH-1, no overflow.

Reset
REQ-035 p_in_rst=1 at any time, including mid-frame: next edge FSM=IDLE, x=y=0, tvalid, tuser, tlast, busy, frame_done=0, tdata=0.
REQ-036 Reset takes priority over start and handshake in the same cycle; no partial frame resumes after reset.

Verification
REQ-037 PIXEL_WIDTH=8, CH_COUNT=1, mode 2, w=h=25, cx=cy=12, tready=1 -> 625 beats; row 12 x=9..15 = 31,95,191,255,191,95,31; all else 0; one frame_done.
REQ-038 mode 1, w=4, h=2, tready toggled pseudo-randomly -> beats 0,1,2,3,0,1,2,3; tlast on x=3; tuser only first; data stable during stalls.
REQ-039 mode 3, blk=1, w=h=4 -> rows 0-1: 0,0,255,255; rows 2-3: 255,255,0,0.
REQ-040 cont=1, mode 0, val=0x5A, w=h=2, CH_COUNT=3 -> tdata=0x5A5A5A, back-to-back frames, tuser every 4th beat, frame_done every frame.
REQ-041 Reset asserted at pixel (3,5) of 25x25 frame -> next cycle tvalid=0, busy=0; new start gives fresh frame with tuser on (0,0).
REQ-042 start with w=0 -> busy stays 0, no tvalid, no frame_done.
